// File: rtl/mem_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter_if
// Purpose : single valid/ready memory request port plus its response return
//           path, shared between the request arbiter and the memory model.
// Signals :
//   req_valid  arbiter -> memory  request valid
//   req_ready  memory  -> arbiter request accepted
//   req_we     arbiter -> memory  1=write, 0=read
//   req_addr   arbiter -> memory  request address (AW bits)
//   req_id     arbiter -> memory  requester index (IDW bits)
//   resp_valid memory  -> arbiter one-cycle completion pulse
//   resp_id    memory  -> arbiter id of the completed transaction
// Modports: master = arbiter side, slave = memory side.
// ----------------------------------------------------------------------------
interface mem_req_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 32
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [AW-1:0]  req_addr;
  logic [IDW-1:0] req_id;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;

  modport master (
    output req_valid, req_we, req_addr, req_id,
    input  req_ready, resp_valid, resp_id
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_id,
    output req_ready, resp_valid, resp_id
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter
// Purpose : collects per-cache memory read/write requests into one pending
//           slot per cache, arbitrates the slots round-robin onto a single
//           valid/ready memory port, keeps one transaction outstanding and
//           returns a one-cycle done pulse to the cache whose transaction
//           completed.
// Ports   :
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   mem_read_i     [N]      per-cache read request (level)
//   mem_write_i    [N]      per-cache write/writeback request (level)
//   addr_i         [N][AW]  per-cache request address
//   pend_o         [N]      slot holds an unserved request
//   done_o         [N]      one-cycle completion pulse, one-hot or zero
//   err_overflow_o          sticky: request dropped (slot busy or rd+wr)
//   err_resp_o              sticky: unexpected or mismatched response
//   mem_if                  memory request/response port (master side)
// ----------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int N  = 2,
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  mem_read_i,
  input  logic [N-1:0]  mem_write_i,
  input  logic [AW-1:0] addr_i [N],
  output logic [N-1:0]  pend_o,
  output logic [N-1:0]  done_o,
  output logic          err_overflow_o,
  output logic          err_resp_o,
  mem_req_arbiter_if.master mem_if
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]   ONE_N     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0] LAST_RST  = IDW'(N-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e         state_q,      state_d;
  logic [N-1:0]   pend_q,       pend_d;
  logic [N-1:0]   done_q,       done_d;
  logic [N-1:0]   slot_we_q,    slot_we_d;
  logic [AW-1:0]  slot_addr_q [N];
  logic [AW-1:0]  slot_addr_d [N];
  logic [IDW-1:0] grant_q,      grant_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic           req_valid_q,  req_valid_d;
  logic           req_we_q,     req_we_d;
  logic [AW-1:0]  req_addr_q,   req_addr_d;
  logic           err_ovf_q,    err_ovf_d;
  logic           err_resp_q,   err_resp_d;

  logic           comp_s;
  logic [N-1:0]   comp_vec_s;
  logic [N-1:0]   req_s;
  logic [N-1:0]   free_s;
  logic [N-1:0]   cap_s;
  logic [N-1:0]   ovf_vec_s;
  logic           rr_found_s;
  logic [IDW-1:0] rr_idx_s;

  // The granted slot completes when its matching response arrives in WAIT.
  assign comp_s     = (state_q == ST_WAIT) && mem_if.resp_valid && (mem_if.resp_id == grant_q);
  assign comp_vec_s = comp_s ? (ONE_N << grant_q) : {N{1'b0}};

  // A slot completing this cycle is free again, so a held request re-captures.
  assign req_s     = mem_read_i | mem_write_i;
  assign free_s    = ~pend_q | comp_vec_s;
  assign cap_s     = req_s & free_s;
  assign ovf_vec_s = (mem_read_i & mem_write_i) | (req_s & ~free_s);

  // Slot capture, pending flags, done pulse and the overflow flag.
  always_comb begin
    pend_d    = (pend_q & ~comp_vec_s) | cap_s;
    done_d    = comp_vec_s;
    err_ovf_d = err_ovf_q | (|ovf_vec_s);
    slot_we_d = slot_we_q;
    for (int i = 0; i < N; i++) begin
      slot_addr_d[i] = slot_addr_q[i];
      if (cap_s[i]) begin
        // Write wins when both are raised; the read is the dropped one.
        slot_we_d[i]   = mem_write_i[i];
        slot_addr_d[i] = addr_i[i];
      end else begin
        slot_we_d[i]   = slot_we_q[i];
        slot_addr_d[i] = slot_addr_q[i];
      end
    end
  end

  // Round-robin pick: first pending slot strictly after the last grant.
  always_comb begin : rr_sel
    int cand_v;
    cand_v     = 0;
    rr_found_s = 1'b0;
    rr_idx_s   = {IDW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand_v = (int'(last_grant_q) + k) % N;
      if (!rr_found_s && pend_q[cand_v]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = IDW'(cand_v);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Transaction FSM: next state, request port contents and response checks.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_valid_d  = req_valid_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    err_resp_d   = err_resp_q;
    case (state_q)
      ST_IDLE: begin
        // Responses here are stale (e.g. from before a reset) and ignored.
        if (rr_found_s) begin
          grant_d     = rr_idx_s;
          req_we_d    = slot_we_q[rr_idx_s];
          req_addr_d  = slot_addr_q[rr_idx_s];
          req_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_if.resp_valid) begin
          err_resp_d = 1'b1;
        end else begin
          err_resp_d = err_resp_q;
        end
        if (mem_if.req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_if.resp_valid) begin
          if (mem_if.resp_id == grant_q) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            err_resp_d = 1'b1;
            state_d    = ST_WAIT;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops everything immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pend_q       <= {N{1'b0}};
      done_q       <= {N{1'b0}};
      slot_we_q    <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        slot_addr_q[i] <= {AW{1'b0}};
      end
      grant_q      <= {IDW{1'b0}};
      last_grant_q <= LAST_RST;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= {AW{1'b0}};
      err_ovf_q    <= 1'b0;
      err_resp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      done_q       <= done_d;
      slot_we_q    <= slot_we_d;
      for (int i = 0; i < N; i++) begin
        slot_addr_q[i] <= slot_addr_d[i];
      end
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req_valid_q  <= req_valid_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      err_ovf_q    <= err_ovf_d;
      err_resp_q   <= err_resp_d;
    end
  end

  assign pend_o           = pend_q;
  assign done_o           = done_q;
  assign err_overflow_o   = err_ovf_q;
  assign err_resp_o       = err_resp_q;
  assign mem_if.req_valid = req_valid_q;
  assign mem_if.req_we    = req_we_q;
  assign mem_if.req_addr  = req_addr_q;
  assign mem_if.req_id    = grant_q;

endmodule
